// File: rtl/fixed_pkg.sv
// Shared signed fixed-point helpers: rounding/shift and narrowing with saturation.
// Sized for the widest result in use; callers pass their own width and take low bits.
package fixed_pkg;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

    // Widest result width any user may request (W must not exceed this).
    localparam int MAX_W = 32;
    // Full product plus one bit of headroom for the rounding increment.
    localparam int WIDE  = 2 * MAX_W + 1;

    typedef logic signed [WIDE-1:0] wide_t;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] val;
    } sat_t;

    // Optional round-half-up increment, then arithmetic shift right by q.
    function automatic wide_t round_shift(input wide_t p, input int q, input int rnd);
        wide_t r;
        r = p;
        if (rnd == RND_HALF_UP && q > 0) begin
            r = p + (wide_t'(1) <<< (q - 1));
        end
        return r >>> q;
    endfunction

    // Flags values outside the w-bit signed range and clamps them to it.
    function automatic sat_t sat_narrow(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        sat_t  res;
        hi      = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo      = -(wide_t'(1) <<< (w - 1));
        res.ovf = (v > hi) || (v < lo);
        if (v > hi) begin
            res.val = hi[MAX_W-1:0];
        end else if (v < lo) begin
            res.val = lo[MAX_W-1:0];
        end else begin
            res.val = v[MAX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/multiply_pipe_if.sv
// Operand/result bus of the pipelined multiplier.
// Handshake: a transfer happens on a rising clk edge where strobe and ready are
// both high. The source holds strobe and data steady until that edge; ready may
// depend combinationally on strobe. Input side: both s_stb bits must be high and
// the two s_rdy bits are always equal, so A and B are consumed together.
interface multiply_pipe_if #(parameter int W = 8);
    logic [1:0]     s_stb;
    logic [2*W-1:0] s_dat;
    logic [1:0]     s_rdy;
    logic           m_rdy;
    logic           m_stb;
    logic [W-1:0]   m_dat;
    logic           m_ovf;
    logic           busy;

    modport master (output s_stb, s_dat, m_rdy,
                    input  s_rdy, m_stb, m_dat, m_ovf, busy);
    modport slave  (input  s_stb, s_dat, m_rdy,
                    output s_rdy, m_stb, m_dat, m_ovf, busy);
endinterface

// File: rtl/pipe_stage.sv
// One elastic register stage: loads whenever it is empty or downstream advances,
// so bubbles collapse and a full pipeline still moves one item per cycle.
module pipe_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld_i,
    input  logic [PW-1:0] in_dat_i,
    input  logic          adv_in_i,   // downstream stage (or sink) will take our item
    output logic          adv_o,      // this stage loads on the next edge
    output logic          vld_o,
    output logic [PW-1:0] dat_o
);
    logic          vld_q;
    logic [PW-1:0] dat_q;

    assign adv_o = ~vld_q | adv_in_i;
    assign vld_o = vld_q;
    assign dat_o = dat_q;

    // Valid follows upstream on advance; payload only reloads with real data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (adv_o) begin
            vld_q <= in_vld_i;
            if (in_vld_i) begin
                dat_q <= in_dat_i;
            end
        end
    end
endmodule

// File: rtl/multiply_pipe.sv
// Pipelined signed fixed-point multiplier: product enters stage 1, stages
// 2..D-1 only delay it, and the last stage rounds, shifts and narrows on load.
module multiply_pipe
    import fixed_pkg::*;
#(
    parameter int W   = 8,   // operand/result width, 2 <= W <= MAX_W
    parameter int Q   = 0,   // fractional bits
    parameter int D   = 2,   // register stages = latency
    parameter int RND = 0,   // RND_TRUNC or RND_HALF_UP
    parameter int SAT = 1    // 1 clamp, 0 wrap
) (
    input  logic           clk,
    input  logic           rst,
    multiply_pipe_if.slave bus
);
    localparam int PW = 2 * W;

    // Index 0 is the combinational product at the stage-1 input.
    logic          p_vld [0:D-1];
    logic [PW-1:0] p_dat [0:D-1];
    logic          adv   [1:D];
    logic          accept;
    logic          out_vld;
    logic [W:0]    out_dat_d;
    logic [W:0]    out_dat_q;
    logic          busy_d;
    logic signed [PW-1:0] prod_d;

    // Round, shift, then narrow; overflow is reported in both clamp and wrap modes.
    function automatic logic [W:0] post_process(input logic [PW-1:0] p);
        wide_t r;
        sat_t  s;
        r = round_shift({{(WIDE-PW){p[PW-1]}}, p}, Q, RND);
        s = sat_narrow(r, W);
        if (SAT != 0) begin
            return {s.ovf, s.val[W-1:0]};
        end
        return {s.ovf, r[W-1:0]};
    endfunction

    assign accept    = (&bus.s_stb) & adv[1];
    assign bus.s_rdy = {2{accept}};
    assign prod_d    = $signed(bus.s_dat[W-1:0]) * $signed(bus.s_dat[PW-1:W]);
    assign p_vld[0]  = accept;
    assign p_dat[0]  = prod_d;
    assign out_dat_d = post_process(p_dat[D-1]);

    genvar k;
    generate
        for (k = 1; k < D; k++) begin : g_mid
            pipe_stage #(.PW(PW)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .in_vld_i (p_vld[k-1]),
                .in_dat_i (p_dat[k-1]),
                .adv_in_i (adv[k+1]),
                .adv_o    (adv[k]),
                .vld_o    (p_vld[k]),
                .dat_o    (p_dat[k])
            );
        end
    endgenerate

    pipe_stage #(.PW(W + 1)) u_out (
        .clk      (clk),
        .rst      (rst),
        .in_vld_i (p_vld[D-1]),
        .in_dat_i (out_dat_d),
        .adv_in_i (bus.m_rdy),
        .adv_o    (adv[D]),
        .vld_o    (out_vld),
        .dat_o    (out_dat_q)
    );

    assign bus.m_stb = out_vld;
    assign bus.m_ovf = out_dat_q[W];
    assign bus.m_dat = out_dat_q[W-1:0];
    assign bus.busy  = busy_d;

    // Busy whenever any stage holds an item.
    always_comb begin
        busy_d = out_vld;
        for (int i = 1; i < D; i++) begin
            busy_d = busy_d | p_vld[i];
        end
    end
endmodule

// File: tb/tb_multiply_pipe.sv
// Directed bench: three W=8, Q=4, D=3 instances (trunc+sat, round+sat, trunc+wrap)
// share one stimulus stream; a negedge monitor keeps the expected queues.
`timescale 1ns/1ps
module tb_multiply_pipe;
    localparam int W  = 8;
    localparam int Q  = 4;
    localparam int D  = 3;
    localparam int NV = 14;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]     s_stb = 2'b00;
    logic [2*W-1:0] s_dat = '0;
    logic           m_rdy = 1'b0;
    int             cur_idx = 0;

    multiply_pipe_if #(.W(W)) if_a ();
    multiply_pipe_if #(.W(W)) if_b ();
    multiply_pipe_if #(.W(W)) if_c ();

    assign if_a.s_stb = s_stb;  assign if_a.s_dat = s_dat;  assign if_a.m_rdy = m_rdy;
    assign if_b.s_stb = s_stb;  assign if_b.s_dat = s_dat;  assign if_b.m_rdy = m_rdy;
    assign if_c.s_stb = s_stb;  assign if_c.s_dat = s_dat;  assign if_c.m_rdy = m_rdy;

    multiply_pipe #(.W(W), .Q(Q), .D(D), .RND(0), .SAT(1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    multiply_pipe #(.W(W), .Q(Q), .D(D), .RND(1), .SAT(1)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    multiply_pipe #(.W(W), .Q(Q), .D(D), .RND(0), .SAT(0)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    // ---------------- vectors: A, B, expected {ovf,dat} per instance ----------------
    logic [7:0] va [NV] = '{8'h18, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h80, 8'h10,
                            8'hF0, 8'h30, 8'hE0, 8'h7F, 8'h03, 8'hFD, 8'h81};
    logic [7:0] vb [NV] = '{8'h20, 8'h08, 8'h08, 8'h7F, 8'h7F, 8'h80, 8'h10,
                            8'h10, 8'h30, 8'h40, 8'h10, 8'h05, 8'h05, 8'h81};
    logic [8:0] ea [NV] = '{9'h030, 9'h000, 9'h0FF, 9'h17F, 9'h180, 9'h17F, 9'h010,
                            9'h0F0, 9'h17F, 9'h080, 9'h07F, 9'h000, 9'h0FF, 9'h17F};
    logic [8:0] eb [NV] = '{9'h030, 9'h001, 9'h000, 9'h17F, 9'h180, 9'h17F, 9'h010,
                            9'h0F0, 9'h17F, 9'h080, 9'h07F, 9'h001, 9'h0FF, 9'h17F};
    logic [8:0] ec [NV] = '{9'h030, 9'h000, 9'h0FF, 9'h1F0, 9'h108, 9'h100, 9'h010,
                            9'h0F0, 9'h190, 9'h080, 9'h07F, 9'h000, 9'h0FF, 9'h1F0};

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [8:0]   exp_a[$];
    logic [8:0]   exp_b[$];
    logic [8:0]   exp_c[$];
    logic [8:0]   e_a, e_b, e_c;
    bit           stalled = 0;
    logic [W-1:0] hold_dat;
    logic         hold_ovf;
    int           out_cnt = 0;
    int           stall_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_a.delete();
            exp_b.delete();
            exp_c.delete();
            stalled = 0;
        end else begin
            // ready model: join both strobes; space exists unless all D stages hold and sink stalls
            check("s_rdy", {30'd0, if_a.s_rdy},
                  (&s_stb && (exp_a.size() < D || m_rdy)) ? 32'd3 : 32'd0);
            check("busy", {31'd0, if_a.busy}, {31'd0, exp_a.size() != 0});
            if (stalled) begin
                check("hold_stb", {31'd0, if_a.m_stb}, 32'd1);
                check("hold_dat", {24'd0, if_a.m_dat}, {24'd0, hold_dat});
                check("hold_ovf", {31'd0, if_a.m_ovf}, {31'd0, hold_ovf});
            end
            if (&s_stb && !if_a.s_rdy[0]) stall_cnt++;
            if (if_a.m_stb) begin
                if (exp_a.size() == 0) begin
                    check("unexpected_out", {31'd0, if_a.m_stb}, 32'd0);
                end else if (m_rdy) begin
                    e_a = exp_a.pop_front();
                    e_b = exp_b.pop_front();
                    e_c = exp_c.pop_front();
                    check("out_a", {23'd0, if_a.m_ovf, if_a.m_dat}, {23'd0, e_a});
                    check("out_b", {22'd0, if_b.m_stb, if_b.m_ovf, if_b.m_dat}, {22'd0, 1'b1, e_b});
                    check("out_c", {22'd0, if_c.m_stb, if_c.m_ovf, if_c.m_dat}, {22'd0, 1'b1, e_c});
                    out_cnt++;
                end
            end
            if (&s_stb && if_a.s_rdy[0]) begin
                exp_a.push_back(ea[cur_idx]);
                exp_b.push_back(eb[cur_idx]);
                exp_c.push_back(ec[cur_idx]);
            end
            stalled  = if_a.m_stb && !m_rdy;
            hold_dat = if_a.m_dat;
            hold_ovf = if_a.m_ovf;
        end
    end

    // ---------------- driver tasks ----------------
    // Present vector idx and hold it until accepted; returns just after the accept edge.
    task automatic send(input int idx);
        bit got;
        got     = 0;
        s_stb   = 2'b11;
        s_dat   = {vb[idx], va[idx]};
        cur_idx = idx;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (if_a.s_rdy[0]) begin
                got = 1;
                break;
            end
        end
        if (!got) check("send_timeout", {30'd0, if_a.s_rdy}, 32'd3);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            #1;
            if (exp_a.size() == 0 && !if_a.busy) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", exp_a.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int base;

    initial begin
        rst   = 1'b1;
        m_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_stb", {31'd0, if_a.m_stb}, 32'd0);
        check("rst_m_dat", {24'd0, if_a.m_dat}, 32'd0);
        check("rst_m_ovf", {31'd0, if_a.m_ovf}, 32'd0);
        check("rst_busy",  {31'd0, if_a.busy},  32'd0);
        rst = 1'b0;

        // latency: result valid three cycles after the accept cycle
        m_rdy = 1'b1;
        send(0);
        s_stb = 2'b00;
        check("lat_c1", {31'd0, if_a.m_stb}, 32'd0);
        @(posedge clk); #1;
        check("lat_c2", {31'd0, if_a.m_stb}, 32'd0);
        @(posedge clk); #1;
        check("lat_c3", {31'd0, if_a.m_stb}, 32'd1);
        wait_idle();

        // full-rate stream of all remaining vectors
        stall_cnt = 0;
        base = out_cnt;
        for (int i = 1; i < NV; i++) send(i);
        s_stb = 2'b00;
        wait_idle();
        check("thru_stalls", stall_cnt, 32'd0);
        check("thru_count", out_cnt - base, NV - 1);

        // join: a single strobe is never accepted
        base  = out_cnt;
        s_stb = 2'b01;
        s_dat = {vb[6], va[6]};
        repeat (5) begin @(posedge clk); #1; end
        s_stb = 2'b10;
        repeat (2) begin @(posedge clk); #1; end
        check("join_no_out", out_cnt - base, 32'd0);
        check("join_idle", {31'd0, if_a.busy}, 32'd0);
        send(6);
        s_stb = 2'b00;
        wait_idle();
        check("join_one_out", out_cnt - base, 32'd1);

        // backpressure: sink stalls for six cycles mid-stream
        stall_cnt = 0;
        base = out_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) send(i);
                s_stb = 2'b00;
            end
            begin
                m_rdy = 1'b1;
                repeat (3) @(posedge clk);
                #1 m_rdy = 1'b0;
                repeat (6) @(posedge clk);
                #1 m_rdy = 1'b1;
            end
        join
        wait_idle();
        check("bp_count", out_cnt - base, 32'd8);
        check("bp_stalled", {31'd0, stall_cnt != 0}, 32'd1);

        // reset with three results in flight
        m_rdy = 1'b0;
        base  = out_cnt;
        send(3);
        send(4);
        send(5);
        s_stb = 2'b00;
        check("pre_rst_busy", {31'd0, if_a.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_m_stb", {31'd0, if_a.m_stb}, 32'd0);
        check("mid_rst_m_dat", {24'd0, if_a.m_dat}, 32'd0);
        check("mid_rst_busy",  {31'd0, if_a.busy},  32'd0);
        m_rdy = 1'b1;
        send(7);
        s_stb = 2'b00;
        wait_idle();
        repeat (4) begin @(posedge clk); #1; end
        check("post_rst_count", out_cnt - base, 32'd1);
        check("final_q", exp_a.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
